// File: rtl/alu16.sv
// alu16: registered 16-bit ALU, 1-cycle latency, no backpressure (every in_valid op is accepted).
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags output.
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] op_lhs,
    input  logic [WIDTH-1:0] op_rhs,
    output logic [WIDTH-1:0] result,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);
    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_OR  = 3'b011,
        OP_AND = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    localparam int SHW = $clog2(WIDTH);

    op_e              w_op;
    logic             w_sh_ovr;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;

    assign w_op     = op_e'(operation);
    // WIDTH is a power of two, so any set bit above the index field means rhs >= WIDTH
    assign w_sh_ovr = |op_rhs[WIDTH-1:SHW];
    assign w_shamt  = op_rhs[SHW-1:0];

    always_comb begin
        w_res = '0;
        case (w_op)
            OP_NOP:  w_res = '0;
            OP_ADD:  w_res = op_lhs + op_rhs;
            OP_SUB:  w_res = op_lhs - op_rhs;
            OP_OR:   w_res = op_lhs | op_rhs;
            OP_AND:  w_res = op_lhs & op_rhs;
            OP_XOR:  w_res = op_lhs ^ op_rhs;
            OP_SHL:  w_res = w_sh_ovr ? '0 : (op_lhs << w_shamt);
            OP_SHR:  w_res = w_sh_ovr ? '0 : (op_lhs >> w_shamt);
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_res;
            end
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_valid;

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_c;
    logic           w_v;
    logic [3:0]     w_flags;
    logic [3:0]     r_flags;

    assign w_sum  = {1'b0, op_lhs} + {1'b0, op_rhs};
    assign w_diff = {1'b0, op_lhs} - {1'b0, op_rhs};

    // C is carry-out for ADD and borrow for SUB; V is two's-complement overflow
    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_c = w_sum[WIDTH];
                w_v = (op_lhs[WIDTH-1] == op_rhs[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != op_lhs[WIDTH-1]);
            end
            OP_SUB: begin
                w_c = w_diff[WIDTH];
                w_v = (op_lhs[WIDTH-1] != op_rhs[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != op_lhs[WIDTH-1]);
            end
            default: begin
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    assign w_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (in_valid) begin
            r_flags <= w_flags;
        end
    end

    assign flags = r_flags;
`endif

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed spec cases, reset, handshake, then randomized ops.
module tb_alu16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  operation;
    logic [15:0] op_lhs;
    logic [15:0] op_rhs;
    logic [15:0] result;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic [3:0]  flags;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_res;
    logic        exp_vld;
    logic [3:0]  exp_flg;
    string       prev_tag;

    always #5 clk = ~clk;

    alu16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operation (operation),
        .op_lhs    (op_lhs),
        .op_rhs    (op_rhs),
        .result    (result),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^16
    function automatic logic [15:0] model(input logic [2:0] op, input longint l, input longint r);
        longint v;
        case (op)
            3'd1:    v = (l + r) % 65536;
            3'd2:    v = (l - r + 65536) % 65536;
            3'd3:    v = l | r;
            3'd4:    v = l & r;
            3'd5:    v = l ^ r;
            3'd6:    v = (r >= 16) ? 0 : (l * (longint'(1) << r)) % 65536;
            3'd7:    v = (r >= 16) ? 0 : l / (longint'(1) << r);
            default: v = 0;
        endcase
        return 16'(v);
    endfunction

    function automatic logic [3:0] model_flags(input logic [2:0] op, input longint l, input longint r,
                                               input logic [15:0] res);
        longint sl;
        longint sr;
        longint s;
        logic   c;
        logic   v;
        sl = (l >= 32768) ? l - 65536 : l;
        sr = (r >= 32768) ? r - 65536 : r;
        c  = 1'b0;
        v  = 1'b0;
        if (op == 3'd1) begin
            c = (l + r) > 65535;
            s = sl + sr;
            v = (s > 32767) || (s < -32768);
        end else if (op == 3'd2) begin
            c = l < r;
            s = sl - sr;
            v = (s > 32767) || (s < -32768);
        end
        return {res[15], res == 16'd0, c, v};
    endfunction

    task automatic check_outputs();
        check_eq({prev_tag, "/vld"}, 32'(out_valid), 32'(exp_vld));
        check_eq({prev_tag, "/res"}, 32'(result), 32'(exp_res));
`ifdef ALU_FLAGS_EN
        check_eq({prev_tag, "/flg"}, 32'(flags), 32'(exp_flg));
`endif
    endtask

    // Checks the outcome of the previous cycle's inputs, then drives this cycle's.
    task automatic step(input logic v, input logic [2:0] op, input logic [15:0] l,
                        input logic [15:0] r, input string tag);
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        operation = op;
        op_lhs    = l;
        op_rhs    = r;
        prev_tag  = tag;
        exp_vld   = v;
        if (v) begin
            exp_res = model(op, longint'(l), longint'(r));
            exp_flg = model_flags(op, longint'(l), longint'(r), exp_res);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operation = 3'd0;
        op_lhs    = 16'd0;
        op_rhs    = 16'd0;
        exp_res   = 16'd0;
        exp_vld   = 1'b0;
        exp_flg   = 4'd0;
        prev_tag  = "reset";
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 3'd1, 16'd10000, 16'd20000, "add_basic");
        step(1'b1, 3'd1, 16'hFFFF,  16'h0001,  "add_wrap");
        step(1'b1, 3'd2, 16'd30000, 16'd10000, "sub_basic");
        step(1'b1, 3'd2, 16'd0,     16'd1,     "sub_wrap");
        step(1'b1, 3'd3, 16'h0F0F,  16'hF0F0,  "or");
        step(1'b1, 3'd4, 16'hFFFF,  16'hAAAA,  "and");
        step(1'b1, 3'd5, 16'hAAAA,  16'h5555,  "xor");
        step(1'b1, 3'd6, 16'd10000, 16'd0,     "shl_0");
        step(1'b1, 3'd6, 16'h0001,  16'd15,    "shl_15");
        step(1'b1, 3'd6, 16'hFFFF,  16'd16,    "shl_16");
        step(1'b1, 3'd7, 16'd0,     16'd20000, "shr_big");
        step(1'b1, 3'd7, 16'h8000,  16'd15,    "shr_15");
        step(1'b1, 3'd7, 16'hFFFF,  16'h0110,  "shr_hi_bits");
        step(1'b1, 3'd0, 16'h1234,  16'h5678,  "nop");
        step(1'b1, 3'd1, 16'h7FFF,  16'h0001,  "add_ovf");
        step(1'b1, 3'd2, 16'h8000,  16'h0001,  "sub_ovf");

        // Three back-to-back valids, then idle: result must hold
        step(1'b1, 3'd1, 16'd1,     16'd2,     "b2b_0");
        step(1'b1, 3'd5, 16'h00FF,  16'h0F0F,  "b2b_1");
        step(1'b1, 3'd2, 16'd500,   16'd700,   "b2b_2");
        step(1'b0, 3'd1, 16'hFFFF,  16'hFFFF,  "idle_0");
        step(1'b0, 3'd3, 16'h1111,  16'h2222,  "idle_1");

        // Mid-run async reset with an op pending: outputs clear without a clock edge
        step(1'b1, 3'd1, 16'd1,     16'd1,     "pre_rst");
        step(1'b1, 3'd1, 16'd5,     16'd5,     "pending");
        #2;
        rst_n = 1'b0;
        #1;
        exp_res  = 16'd0;
        exp_vld  = 1'b0;
        exp_flg  = 4'd0;
        prev_tag = "async_rst";
        check_outputs();
        @(negedge clk);
        prev_tag = "rst_held";
        check_outputs();
        in_valid = 1'b0;
        rst_n    = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [15:0] l;
            logic [15:0] r;
            op = 3'($urandom_range(0, 7));
            l  = 16'($urandom);
            r  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            step($urandom_range(0, 3) != 0, op, l, r, $sformatf("rnd%0d_op%0d", i, op));
        end
        step(1'b0, 3'd0, 16'd0, 16'd0, "flush");
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
